onchip_mem_arbiter: RTL and testbench
=====================================

ONCHIP_MEM_ARBITER -- requirements
Module: onchip_mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 15, word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-003 The block SHALL have parameter NUM_WORDS, default 17740, number of implemented memory words.
REQ-004 The block SHALL have port clk, input, 1, single clock for all logic.
REQ-005 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 For each requester mN (N = 0, 1), the block SHALL have inputs mN_address (ADDR_W), mN_byteenable (DATA_W/8), mN_read (1), mN_write (1) and mN_writedata (DATA_W).
REQ-007 For each requester mN, the block SHALL have outputs mN_waitrequest (1), mN_readdata (DATA_W) and mN_readdatavalid (1).
REQ-008 The block SHALL have outputs mem_address (ADDR_W), mem_byteenable (DATA_W/8), mem_chipselect (1), mem_write (1), mem_writedata (DATA_W) and mem_clken (1), driving the single-port RAM.
REQ-009 The block SHALL have input mem_readdata (DATA_W); the RAM returns data one clk after the address is presented.
REQ-010 The block SHALL have input freeze (1), a request to quiesce the memory.
REQ-011 The block SHALL have outputs frozen (1), err_oor (1) and err_rw (1), plus input err_clr (1).

Function
REQ-012 The block SHALL issue at most one access per cycle; reads SHALL be fully pipelined with one access per cycle sustained.
REQ-013 A request from mN SHALL be mN_read or mN_write high while the block is in state RUN.
REQ-014 A single requester SHALL be granted in the same cycle; its waitrequest SHALL be 0 and its command SHALL be forwarded combinationally to mem_*.
REQ-015 When both requesters request, the block SHALL grant the requester not recorded in last_grant; last_grant SHALL update on every grant.
REQ-016 The non-granted requester SHALL see waitrequest = 1 and SHALL hold its command stable.
REQ-017 With no request, the block SHALL drive mem_chipselect = 0 and mem_write = 0; both waitrequests SHALL be 0.
REQ-018 Read latency SHALL be exactly 1 clk: mN_readdatavalid SHALL pulse the cycle after the granted read, with mN_readdata = mem_readdata.
REQ-019 The other requester's readdatavalid SHALL stay 0, and its readdata SHALL hold its last value.
REQ-020 A write SHALL complete in its grant cycle and SHALL produce no readdatavalid.
REQ-021 An address >= NUM_WORDS SHALL be out of range: mem_chipselect = 0 for that access, and the write is dropped.
REQ-022 An out-of-range read SHALL return readdata = 0 with readdatavalid on the usual 1-clk latency, and SHALL set sticky err_oor.
REQ-023 When read and write are both high from one requester, the block SHALL treat the request as a write and SHALL set sticky err_rw.
REQ-024 err_clr SHALL clear both sticky error bits; an error event in the same cycle SHALL win, leaving the bit set.
REQ-025 The FSM SHALL have states RUN, DRAIN and FROZEN.
REQ-026 RUN SHALL go to DRAIN when freeze = 1.
REQ-027 DRAIN SHALL grant nothing and drive both waitrequests = 1, and SHALL go to FROZEN once no read is outstanding; this takes 1 clk if a read was issued in the previous cycle, otherwise it is immediate on the next edge.
REQ-028 In FROZEN the block SHALL drive frozen = 1, mem_clken = 0 and both waitrequests = 1.
REQ-029 FROZEN SHALL go to RUN when freeze = 0; frozen and mem_clken SHALL update registered on that same edge.
REQ-030 In DRAIN, a freeze deassertion SHALL be ignored until FROZEN is reached.
REQ-031 mem_clken SHALL be 1 in RUN and DRAIN.

Reset
REQ-032 While reset_n = 0, the block SHALL hold state = RUN, last_grant = 1 (requester 0 wins first contention), read pipeline valid = 0 and readdata registers = 0.
REQ-033 While reset_n = 0, the block SHALL hold err_oor = err_rw = 0, frozen = 0 and mem_clken = 1.
REQ-034 A reset asserted mid-read SHALL discard the outstanding read, and no readdatavalid SHALL follow the reset release.

Structure
REQ-035 A shared package onchip_mem_pkg SHALL hold the ADDR_W, DATA_W and NUM_WORDS defaults and the FSM state enum (RUN/DRAIN/FROZEN).
REQ-036 A single sub-module rr_arb2 SHALL hold the two-way round-robin grant logic and the last_grant register; the read-return pipeline and FSM SHALL stay in the top.

Verification
REQ-037 Bench scenario, single read: m0 reads addr 0x0010 holding 0xDEADBEEF -> m0_waitrequest = 0 and, 1 clk later, m0_readdatavalid = 1 with m0_readdata = 0xDEADBEEF, and m1_readdatavalid stays 0.
REQ-038 Bench scenario, contention: m0 and m1 both read continuously for 6 cycles after reset -> grants alternate m0, m1, m0, ..., with each waitrequest high on alternate cycles and no lost or duplicated returns.
REQ-039 Bench scenario, byte write: m1 writes 0x11223344 with byteenable 0b0101 to 0x0100 pre-filled with 0xFFFFFFFF, then reads it -> 0xFF22FF44.
REQ-040 Bench scenario, out of range: m0 reads 17740 and writes 17741 -> readdata 0 with readdatavalid, mem_chipselect 0 on both, err_oor = 1; err_clr -> 0.
REQ-041 Bench scenario, freeze with read in flight: freeze raised the cycle m0's read is granted -> readdatavalid still delivered, frozen = 1 two clks later, mem_clken = 0, both waitrequests = 1; freeze low -> RUN on the next edge.
REQ-042 Bench scenario, reset mid-read: reset_n asserted asynchronously mid-read -> all outputs return to reset values immediately, and no readdatavalid appears after release.

Source files
------------

// File: rtl/onchip_mem_pkg.sv
// Shared defaults and FSM encoding for the on-chip memory arbiter.
// Imported by the arbiter top and its testbench.
package onchip_mem_pkg;

    localparam int ADDR_W_DEF    = 15;
    localparam int DATA_W_DEF    = 32;
    localparam int NUM_WORDS_DEF = 17740;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        FROZEN = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with the last_grant history register.
// Ports: clk, reset_n, i_req[1:0] requests, o_gnt[1:0] one-hot grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    // Index of the requester granted most recently; 1 out of reset
    // so requester 0 wins the first contention.
    logic r_last;

    always_comb begin
        o_gnt = 2'b00;
        unique case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last <= 1'b1;
        end else if (|o_gnt) begin
            r_last <= o_gnt[1];
        end
    end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Two-requester arbiter in front of a single-port on-chip RAM with
// 1-clk read latency, out-of-range/read-write error flags and freeze.
// Ports: clk/reset_n; m0_*/m1_* requester buses (address, byteenable,
// read, write, writedata -> waitrequest, readdata, readdatavalid);
// mem_* RAM side; freeze -> frozen; err_oor/err_rw sticky, err_clr.
module onchip_mem_arbiter
    import onchip_mem_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int NUM_WORDS = NUM_WORDS_DEF
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata,

    input  logic                freeze,
    output logic                frozen,
    output logic                err_oor,
    output logic                err_rw,
    input  logic                err_clr
);

    localparam int BE_W = DATA_W / 8;

    arb_state_e r_state;
    arb_state_e w_state_nxt;
    logic       w_run;

    logic [1:0] w_req;
    logic [1:0] w_gnt;
    logic       w_any;

    logic [ADDR_W-1:0] w_addr;
    logic [BE_W-1:0]   w_be;
    logic [DATA_W-1:0] w_wd;
    logic              w_rd;
    logic              w_wr;
    logic              w_rw_both;
    logic [31:0]       w_addr32;
    logic              w_oor;
    logic              w_access;

    logic [1:0]        r_pend;
    logic              r_pend_oor;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic [DATA_W-1:0] w_ret;

    logic r_err_oor;
    logic r_err_rw;
    logic r_frozen;
    logic r_clken;

    // FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state and grant enable
    always_comb begin
        w_state_nxt = r_state;
        w_run       = 1'b0;
        unique case (r_state)
            RUN: begin
                w_run = 1'b1;
                if (freeze) begin
                    w_state_nxt = DRAIN;
                end
            end
            // The only read that can be in flight on entry is the one
            // granted in the last RUN cycle; its data is returned in
            // this cycle, so the RAM clock may stop on the next edge.
            // A freeze drop here is deliberately not looked at.
            DRAIN: begin
                w_state_nxt = FROZEN;
            end
            FROZEN: begin
                if (!freeze) begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    assign w_req = {m1_read | m1_write, m0_read | m0_write}
                 & {2{w_run}};

    rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .i_req   (w_req),
        .o_gnt   (w_gnt)
    );

    assign w_any = |w_gnt;

    // Forward the granted command; read+write collapses to a write.
    always_comb begin
        w_addr    = '0;
        w_be      = '0;
        w_wd      = '0;
        w_rd      = 1'b0;
        w_wr      = 1'b0;
        w_rw_both = 1'b0;
        unique case (1'b1)
            w_gnt[0]: begin
                w_addr    = m0_address;
                w_be      = m0_byteenable;
                w_wd      = m0_writedata;
                w_wr      = m0_write;
                w_rd      = m0_read & ~m0_write;
                w_rw_both = m0_read & m0_write;
            end
            w_gnt[1]: begin
                w_addr    = m1_address;
                w_be      = m1_byteenable;
                w_wd      = m1_writedata;
                w_wr      = m1_write;
                w_rd      = m1_read & ~m1_write;
                w_rw_both = m1_read & m1_write;
            end
            default: begin
                w_addr = '0;
            end
        endcase
    end

    assign w_addr32 = 32'(w_addr);
    assign w_oor    = w_addr32 >= 32'(NUM_WORDS);
    assign w_access = w_any & ~w_oor;

    assign mem_address    = w_addr;
    assign mem_byteenable = w_be;
    assign mem_writedata  = w_wd;
    assign mem_chipselect = w_access;
    assign mem_write      = w_access & w_wr;
    assign mem_clken      = r_clken;
    assign frozen         = r_frozen;

    assign m0_waitrequest = w_run ? (w_req[0] & ~w_gnt[0]) : 1'b1;
    assign m1_waitrequest = w_run ? (w_req[1] & ~w_gnt[1]) : 1'b1;

    // Out-of-range reads never touch the RAM and return zero.
    assign w_ret = r_pend_oor ? '0 : mem_readdata;

    assign m0_readdatavalid = r_pend[0];
    assign m1_readdatavalid = r_pend[1];
    assign m0_readdata      = r_pend[0] ? w_ret : r_rdata0;
    assign m1_readdata      = r_pend[1] ? w_ret : r_rdata1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend     <= 2'b00;
            r_pend_oor <= 1'b0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
        end else begin
            r_pend     <= w_gnt & {2{w_rd}};
            r_pend_oor <= w_oor;
            if (r_pend[0]) begin
                r_rdata0 <= w_ret;
            end
            if (r_pend[1]) begin
                r_rdata1 <= w_ret;
            end
        end
    end

    // Sticky errors: a new event outranks a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_oor <= 1'b0;
            r_err_rw  <= 1'b0;
        end else begin
            r_err_oor <= (w_any & w_oor) | (r_err_oor & ~err_clr);
            r_err_rw  <= (w_any & w_rw_both) | (r_err_rw & ~err_clr);
        end
    end

    assign err_oor = r_err_oor;
    assign err_rw  = r_err_rw;

    // frozen/mem_clken follow the state on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frozen <= 1'b0;
            r_clken  <= 1'b1;
        end else begin
            r_frozen <= (w_state_nxt == FROZEN);
            r_clken  <= (w_state_nxt != FROZEN);
        end
    end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: vector table, scoreboard of read
// returns, hand sequences for errors, freeze and reset mid-read.
module tb_onchip_mem_arbiter;
    import onchip_mem_pkg::*;

    localparam int AW = 15;
    localparam int DW = 32;
    localparam int NW = 17740;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    logic [AW-1:0] m0_address = '0, m1_address = '0;
    logic [3:0]    m0_byteenable = '0, m1_byteenable = '0;
    logic          m0_read = 0, m0_write = 0, m1_read = 0, m1_write = 0;
    logic [DW-1:0] m0_writedata = '0, m1_writedata = '0;
    logic          m0_waitrequest, m1_waitrequest;
    logic [DW-1:0] m0_readdata, m1_readdata;
    logic          m0_readdatavalid, m1_readdatavalid;
    logic [AW-1:0] mem_address;
    logic [3:0]    mem_byteenable;
    logic          mem_chipselect, mem_write, mem_clken;
    logic [DW-1:0] mem_writedata;
    logic [DW-1:0] ram_q = '0;
    logic          freeze = 0, err_clr = 0;
    logic          frozen, err_oor, err_rw;

    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    onchip_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(NW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable),
        .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable),
        .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(ram_q),
        .freeze(freeze), .frozen(frozen),
        .err_oor(err_oor), .err_rw(err_rw), .err_clr(err_clr)
    );

    function automatic logic [31:0] init_val(input int a);
        if (a == 16) return 32'hDEADBEEF;
        if (a == 256) return 32'hFFFFFFFF;
        return 32'hA500_0000 | 32'(a);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o,
                                          input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // RAM model: registered read, byte-enabled write, clock-enabled.
    logic [31:0] ram_wr [int];
    int          ram_a;
    logic [31:0] ram_cur;
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            ram_a = int'(mem_address);
            ram_cur = ram_wr.exists(ram_a) ? ram_wr[ram_a]
                                           : init_val(ram_a);
            if (mem_write)
                ram_wr[ram_a] = merge(ram_cur, mem_writedata,
                                      mem_byteenable);
            else
                ram_q <= ram_cur;
        end
    end

    // Reference contents, updated by the bench as writes are granted.
    logic [31:0] ref_wr [int];
    function automatic logic [31:0] ref_val(input int a);
        return ref_wr.exists(a) ? ref_wr[a] : init_val(a);
    endfunction

    task automatic chk1(input string nm, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %b expected %b", nm, a, e);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] a,
                         input logic [31:0] e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    typedef struct {
        bit          port;
        logic [31:0] data;
    } exp_t;
    exp_t sb_q[$];
    logic [31:0] last0 = '0, last1 = '0;

    task automatic sb_pop(input bit p, input logic [31:0] d);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL rd_unexpected: port %0d data %h", p, d);
        end else begin
            e = sb_q.pop_front();
            chk1("rd_port", p, e.port);
            chk32("rd_data", d, e.data);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (m0_readdatavalid) begin
                sb_pop(1'b0, m0_readdata);
                if (!m1_readdatavalid) chk32("rd_hold1", m1_readdata, last1);
                last0 = m0_readdata;
            end
            if (m1_readdatavalid) begin
                sb_pop(1'b1, m1_readdata);
                if (!m0_readdatavalid) chk32("rd_hold0", m0_readdata, last0);
                last1 = m1_readdata;
            end
        end
    end

    // Book a granted access: reads go to the scoreboard, writes
    // update the reference image.
    task automatic book(input bit p, input logic r, input logic w,
                        input logic [AW-1:0] a, input logic [3:0] be,
                        input logic [31:0] wd);
        exp_t e;
        int ai;
        ai = int'(a);
        if (w) begin
            if (ai < NW) ref_wr[ai] = merge(ref_val(ai), wd, be);
        end else if (r) begin
            e.port = p;
            e.data = (ai < NW) ? ref_val(ai) : 32'h0;
            sb_q.push_back(e);
        end
    endtask

    typedef struct {
        logic r0, w0;
        logic [AW-1:0] a0;
        logic r1, w1;
        logic [AW-1:0] a1;
        logic [3:0] be;
        logic [31:0] wd;
        logic ew0, ew1, ecs, ewe;
    } vec_t;

    function automatic vec_t mk(input logic r0, input logic w0,
                                input int a0, input logic r1,
                                input logic w1, input int a1,
                                input logic [3:0] be,
                                input logic [31:0] wd,
                                input logic [3:0] e);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = AW'(a0);
        v.r1 = r1; v.w1 = w1; v.a1 = AW'(a1);
        v.be = be; v.wd = wd;
        {v.ew0, v.ew1, v.ecs, v.ewe} = e;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        m0_read = v.r0; m0_write = v.w0; m0_address = v.a0;
        m1_read = v.r1; m1_write = v.w1; m1_address = v.a1;
        m0_byteenable = v.be; m1_byteenable = v.be;
        m0_writedata = v.wd; m1_writedata = v.wd;
    endtask

    task automatic idle();
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vt[14];

    initial begin
        #400000;
        $display("FAIL watchdog: no finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        bit g0, g1;
        vt[0]  = mk(1,0,'h21, 1,0,'h31, 4'hF, 0, 4'b0110);
        vt[1]  = mk(1,0,'h22, 1,0,'h31, 4'hF, 0, 4'b1010);
        vt[2]  = mk(1,0,'h22, 1,0,'h32, 4'hF, 0, 4'b0110);
        vt[3]  = mk(1,0,'h23, 1,0,'h32, 4'hF, 0, 4'b1010);
        vt[4]  = mk(1,0,'h23, 1,0,'h33, 4'hF, 0, 4'b0110);
        vt[5]  = mk(1,0,'h24, 1,0,'h33, 4'hF, 0, 4'b1010);
        vt[6]  = mk(0,0,0, 0,0,0, 4'hF, 0, 4'b0000);
        vt[7]  = mk(1,0,'h10, 0,0,0, 4'hF, 0, 4'b0010);
        vt[8]  = mk(0,0,0, 0,1,'h100, 4'b0101, 32'h11223344, 4'b0011);
        vt[9]  = mk(0,0,0, 1,0,'h100, 4'hF, 0, 4'b0010);
        vt[10] = mk(1,0,NW, 0,0,0, 4'hF, 0, 4'b0000);
        vt[11] = mk(0,1,NW+1, 0,0,0, 4'hF, 32'h5555AAAA, 4'b0000);
        vt[12] = mk(1,1,'h40, 0,0,0, 4'hF, 32'hCAFEF00D, 4'b0011);
        vt[13] = mk(0,0,0, 1,0,'h40, 4'hF, 0, 4'b0010);

        // Reset values
        #12;
        chk1("rst_wait0", m0_waitrequest, 0);
        chk1("rst_wait1", m1_waitrequest, 0);
        chk1("rst_rdv0", m0_readdatavalid, 0);
        chk1("rst_rdv1", m1_readdatavalid, 0);
        chk32("rst_rd0", m0_readdata, 0);
        chk32("rst_rd1", m1_readdata, 0);
        chk1("rst_cs", mem_chipselect, 0);
        chk1("rst_we", mem_write, 0);
        chk1("rst_frozen", frozen, 0);
        chk1("rst_clken", mem_clken, 1);
        chk1("rst_err_oor", err_oor, 0);
        chk1("rst_err_rw", err_rw, 0);
        step();
        reset_n = 1;
        step();

        // Vector table
        for (int i = 0; i < 14; i++) begin
            v = vt[i];
            drive(v);
            @(negedge clk);
            chk1($sformatf("v%0d_wait0", i), m0_waitrequest, v.ew0);
            chk1($sformatf("v%0d_wait1", i), m1_waitrequest, v.ew1);
            chk1($sformatf("v%0d_cs", i), mem_chipselect, v.ecs);
            chk1($sformatf("v%0d_we", i), mem_write, v.ewe);
            g0 = (v.r0 | v.w0) & ~v.ew0;
            g1 = (v.r1 | v.w1) & ~v.ew1;
            if (v.ecs)
                chk32($sformatf("v%0d_addr", i), 32'(mem_address),
                      g0 ? 32'(v.a0) : 32'(v.a1));
            if (g0) book(0, v.r0, v.w0, v.a0, v.be, v.wd);
            if (g1) book(1, v.r1, v.w1, v.a1, v.be, v.wd);
            step();
        end
        idle();
        @(negedge clk);
        chk1("err_oor_set", err_oor, 1);
        chk1("err_rw_set", err_rw, 1);
        chk32("bytewrite_ref", ref_val('h100), 32'hFF22FF44);

        // err_clr loses against a same-cycle out-of-range event
        step();
        err_clr = 1;
        m0_write = 1; m0_address = AW'(NW + 1);
        step();
        err_clr = 0;
        idle();
        @(negedge clk);
        chk1("clr_vs_evt_oor", err_oor, 1);
        chk1("clr_rw", err_rw, 0);
        step();
        err_clr = 1;
        step();
        err_clr = 0;
        @(negedge clk);
        chk1("clr_oor", err_oor, 0);
        step();

        // Freeze with a read in flight
        m0_read = 1; m0_address = 'h10; freeze = 1;
        @(negedge clk);
        chk1("fz0_wait0", m0_waitrequest, 0);
        chk1("fz0_cs", mem_chipselect, 1);
        book(0, 1, 0, 'h10, 4'hF, 0);
        step();
        m0_read = 0; m1_read = 1; m1_address = 'h20;
        @(negedge clk);
        chk1("fz1_wait0", m0_waitrequest, 1);
        chk1("fz1_wait1", m1_waitrequest, 1);
        chk1("fz1_cs", mem_chipselect, 0);
        chk1("fz1_frozen", frozen, 0);
        chk1("fz1_clken", mem_clken, 1);
        step();
        @(negedge clk);
        chk1("fz2_frozen", frozen, 1);
        chk1("fz2_clken", mem_clken, 0);
        chk1("fz2_wait0", m0_waitrequest, 1);
        chk1("fz2_wait1", m1_waitrequest, 1);
        chk1("fz2_cs", mem_chipselect, 0);
        step();
        freeze = 0;
        @(negedge clk);
        chk1("fz3_frozen", frozen, 1);
        step();
        @(negedge clk);
        chk1("fz4_frozen", frozen, 0);
        chk1("fz4_clken", mem_clken, 1);
        chk1("fz4_wait1", m1_waitrequest, 0);
        chk1("fz4_cs", mem_chipselect, 1);
        book(1, 1, 0, 'h20, 4'hF, 0);
        step();
        idle();
        step();

        // Freeze dropped during DRAIN is ignored
        freeze = 1;
        @(negedge clk);
        chk1("fzb0_wait0", m0_waitrequest, 0);
        step();
        freeze = 0;
        @(negedge clk);
        chk1("fzb1_wait0", m0_waitrequest, 1);
        chk1("fzb1_frozen", frozen, 0);
        step();
        @(negedge clk);
        chk1("fzb2_frozen", frozen, 1);
        step();
        @(negedge clk);
        chk1("fzb3_frozen", frozen, 0);
        step();

        // Reset asserted mid-read
        m0_write = 1; m0_address = AW'(NW + 1);
        step();
        m0_write = 0; m0_read = 1; m0_address = 'h10;
        step();
        m0_read = 0;
        #2;
        reset_n = 0;
        last0 = '0; last1 = '0;
        #1;
        chk1("mrst_rdv0", m0_readdatavalid, 0);
        chk32("mrst_rd0", m0_readdata, 0);
        chk32("mrst_rd1", m1_readdata, 0);
        chk1("mrst_err_oor", err_oor, 0);
        chk1("mrst_frozen", frozen, 0);
        chk1("mrst_clken", mem_clken, 1);
        chk1("mrst_cs", mem_chipselect, 0);
        step();
        step();
        reset_n = 1;
        repeat (3) step();

        // last_grant back to 1: m0 wins the first contention
        m0_read = 1; m0_address = 'h50;
        m1_read = 1; m1_address = 'h60;
        @(negedge clk);
        chk1("post_rst_wait0", m0_waitrequest, 0);
        chk1("post_rst_wait1", m1_waitrequest, 1);
        book(0, 1, 0, 'h50, 4'hF, 0);
        step();
        m0_read = 0;
        @(negedge clk);
        chk1("post_rst2_wait1", m1_waitrequest, 0);
        book(1, 1, 0, 'h60, 4'hF, 0);
        step();
        idle();
        repeat (3) step();

        chk32("sb_empty", 32'(sb_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
